// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared word/address sizing, trit encodings and port-owner type
package memory_port_arbiter_pkg;

    localparam int WORD_SIZE     = 9;
    localparam int MEM_ADDR_SIZE = 6;
    localparam int DATA_W        = 2 * WORD_SIZE;
    localparam int ADDR_W        = 2 * MEM_ADDR_SIZE;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_port_arbiter_rr_pick2.sv
// rtl/memory_port_arbiter_rr_pick2.sv - two-requester round-robin picker with last-grant register
module memory_port_arbiter_rr_pick2
    import memory_port_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    owner_t last;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_if = enable & req_if & (~req_d | (last == OWNER_D));
        gnt_d  = enable & req_d  & (~req_if | (last == OWNER_IF));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last <= OWNER_D;
        end else if (gnt_if) begin
            last <= OWNER_IF;
        end else if (gnt_d) begin
            last <= OWNER_D;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - boot sequencer and fetch/data round-robin owner of the main memory port
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_boot,
    output logic              ld_start,
    input  logic              ld_write,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              cpu_run,
    output logic              boot_fault,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOAD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] load_cnt;
    logic             run_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_boot) state_next = S_START;
            S_START: state_next = S_LOAD;
            S_LOAD: begin
                if (ld_done) begin
                    state_next = S_RUN;
                end else if (load_cnt == CNT_LIMIT) begin
                    state_next = S_FAULT;
                end
            end
            S_RUN:   state_next = S_RUN;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld_start   = (state == S_START);
        cpu_run    = (state == S_RUN);
        boot_fault = (state == S_FAULT);
        run_en     = (state == S_RUN);
    end

    // Cleared on the way into LOAD; saturates so a long LOAD cannot wrap past the limit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt <= '0;
        end else if (state == S_START) begin
            load_cnt <= '0;
        end else if (state == S_LOAD && load_cnt != CNT_LIMIT) begin
            load_cnt <= load_cnt + 1'b1;
        end
    end

    memory_port_arbiter_rr_pick2 u_rr_pick2 (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (run_en),
        .req_if  (if_req),
        .req_d   (d_req),
        .gnt_if  (if_gnt),
        .gnt_d   (d_gnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            if_valid       <= 1'b0;
            d_valid        <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if (state == S_LOAD && ld_write) begin
                mem_addr       <= ld_addr;
                mem_write_data <= ld_wdata;
                mem_write      <= 1'b1;
            end else if (if_gnt) begin
                mem_addr <= if_addr;
                if_valid <= 1'b1;
            end else if (d_gnt) begin
                mem_addr       <= d_addr;
                mem_write_data <= d_wdata;
                mem_write      <= d_we;
                d_valid        <= 1'b1;
            end
        end
    end

    // Read data is steered only to the port that owns this cycle's response.
    always_comb begin
        if_rdata = if_valid ? mem_read_data : '0;
        d_rdata  = d_valid  ? mem_read_data : '0;
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - scoreboard bench for boot, load, arbitration and reset behaviour
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start_boot, ld_start, ld_write, ld_done, cpu_run, boot_fault;
    logic [ADDR_W-1:0] ld_addr, if_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] ld_wdata, d_wdata, if_rdata, d_rdata, mem_write_data, mem_read_data;
    logic              if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid, mem_write;

    int errors = 0;
    int checks = 0;

    localparam logic [DATA_W-1:0] D0 = 18'h15A5A;
    localparam logic [DATA_W-1:0] D1 = 18'h2A5A5;
    localparam logic [DATA_W-1:0] D2 = 18'h00F0F;
    localparam logic [DATA_W-1:0] DX = 18'h24924;

    typedef struct packed {
        logic              mw;
        logic              iv;
        logic              dv;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd;
    } exp_t;

    exp_t exp_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clock = ~clock;

    memory_port_arbiter #(.LOAD_TIMEOUT(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start_boot     (start_boot),
        .ld_start       (ld_start),
        .ld_write       (ld_write),
        .ld_addr        (ld_addr),
        .ld_wdata       (ld_wdata),
        .ld_done        (ld_done),
        .cpu_run        (cpu_run),
        .boot_fault     (boot_fault),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_valid       (if_valid),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_valid        (d_valid),
        .d_rdata        (d_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_write) mem[mem_addr] <= mem_write_data;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic mw, input logic iv, input logic dv,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w,
                                input logic [DATA_W-1:0] r);
        exp_t e;
        e.mw = mw; e.iv = iv; e.dv = dv; e.addr = a; e.wdata = w; e.rd = r;
        return e;
    endfunction

    function automatic logic [127:0] outs_vec();
        return {ld_start, cpu_run, boot_fault, if_gnt, if_valid, if_rdata, d_gnt, d_valid,
                d_rdata, mem_addr, mem_write_data, mem_write};
    endfunction

    // Monitor: every cycle that shows an access is matched against the next expected entry.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && (mem_write || if_valid || d_valid)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access: got mw=%0b iv=%0b dv=%0b addr=%0h expected none",
                         mem_write, if_valid, d_valid, mem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("access",
                      {mem_write, if_valid, d_valid, mem_addr,
                       mem_write ? mem_write_data : {DATA_W{1'b0}}, if_rdata, d_rdata},
                      {e.mw, e.iv, e.dv, e.addr, e.mw ? e.wdata : {DATA_W{1'b0}},
                       e.iv ? e.rd : {DATA_W{1'b0}}, e.dv ? e.rd : {DATA_W{1'b0}}});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        reset_n = 1'b0; start_boot = 0; ld_write = 0; ld_done = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        step();
        check("reset_outputs", outs_vec(), 128'd0);
        reset_n = 1'b1;

        // Boot: three loader writes, the last together with ld_done.
        start_boot = 1;
        #1 check("ld_start_idle", ld_start, 0);
        step(); start_boot = 0;
        #1 check("ld_start_pulse", ld_start, 1);
        step();
        ld_write = 1; ld_addr = 12'd0; ld_wdata = D0; if_req = 1; d_req = 1;
        exp_q.push_back(mk(1, 0, 0, 12'd0, D0, '0));
        #1 check("ld_start_single", ld_start, 0);
        check("no_grant_in_load", {if_gnt, d_gnt}, 0);
        step();
        ld_addr = 12'd1; ld_wdata = D1; if_req = 0; d_req = 0;
        exp_q.push_back(mk(1, 0, 0, 12'd1, D1, '0));
        step();
        ld_addr = 12'd2; ld_wdata = D2; ld_done = 1;
        exp_q.push_back(mk(1, 0, 0, 12'd2, D2, '0));
        #1 check("cpu_run_in_load", cpu_run, 0);
        step();
        ld_write = 0; ld_done = 0;
        #1 check("cpu_run_after_done", cpu_run, 1);

        // Boot/loader inputs are ignored once running.
        start_boot = 1; ld_write = 1; ld_addr = 12'd7; ld_wdata = D0;
        step();
        start_boot = 0; ld_write = 0;
        #1 check("ignored_ld_start", ld_start, 0);
        check("ignored_ld_write", mem_write, 0);

        // Contention: fetch wins the first tie, then strict alternation.
        if_req = 1; if_addr = 12'd1; d_req = 1; d_addr = 12'd2; d_we = 0;
        for (int i = 0; i < 6; i++) begin
            logic want_if;
            want_if = (i % 2 == 0);
            if (want_if) exp_q.push_back(mk(0, 1, 0, 12'd1, '0, D1));
            else         exp_q.push_back(mk(0, 0, 1, 12'd2, '0, D2));
            #1 check("grant_pair", {if_gnt, d_gnt}, {want_if, !want_if});
            step();
        end
        if_req = 0; d_req = 0;

        // Data write then fetch of the same address.
        d_req = 1; d_we = 1; d_addr = 12'd5; d_wdata = DX;
        exp_q.push_back(mk(1, 0, 1, 12'd5, DX, '0));
        #1 check("d_gnt_lone", d_gnt, 1);
        step();
        d_req = 0; d_we = 0; if_req = 1; if_addr = 12'd5;
        exp_q.push_back(mk(0, 1, 0, 12'd5, '0, DX));
        #1 check("if_gnt_lone", if_gnt, 1);
        check("write_ack", {mem_write, d_valid}, 2'b11);
        step();
        if_req = 0;
        #1 check("fetch_readback", {if_valid, if_rdata}, {1'b1, DX});
        step(); step();
        check("queue_drained_run", exp_q.size(), 0);

        // Reset while a loader write is on the memory port.
        reset_n = 0;
        step();
        reset_n = 1; start_boot = 1;
        step();
        start_boot = 0;
        step();
        ld_write = 1; ld_addr = 12'd3; ld_wdata = D2;
        exp_q.push_back(mk(1, 0, 0, 12'd3, D2, '0));
        step();
        ld_write = 0;
        #1 check("mid_load_write", mem_write, 1);
        @(negedge clock);
        #2 reset_n = 0;
        #1 check("reset_async_outputs", outs_vec(), 128'd0);
        step();
        reset_n = 1;

        // Timeout with LOAD_TIMEOUT=8: fault after nine cycles in LOAD.
        start_boot = 1; if_req = 1; d_req = 1;
        step();
        start_boot = 0;
        step();
        for (int k = 0; k < 9; k++) begin
            #1 check("load_no_fault", {boot_fault, if_gnt, d_gnt}, 0);
            step();
        end
        #1 check("fault_raised", {boot_fault, cpu_run, if_gnt, d_gnt}, 4'b1000);
        step();
        #1 check("fault_sticky", {boot_fault, cpu_run, if_gnt, d_gnt}, 4'b1000);
        if_req = 0; d_req = 0;
        step();
        check("queue_drained_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
